// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath constants, jump conditions and writeback entry type
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int REG_AW = 3;

   typedef enum logic [1:0] {
      BR_NONE   = 2'd0,
      BR_ALWAYS = 2'd1,
      BR_IF_N   = 2'd2,
      BR_IF_Z   = 2'd3
   } br_cond_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              n;
      logic              z;
      logic [REG_AW-1:0] rd;
      logic              wr_en;
      logic              flag_en;
      br_cond_e          br_cond;
      logic [DATA_W-1:0] br_target;
   } wb_entry_t;

   // Jumps resolve against the architectural flags as they stood before this retire.
   function automatic logic br_is_taken(br_cond_e cond, logic flag_n, logic flag_z);
      return (cond == BR_ALWAYS) || (cond == BR_IF_N && flag_n) || (cond == BR_IF_Z && flag_z);
   endfunction

endpackage

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order synchronous FIFO of writeback entries with flush
module wb_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_push,
   input  wb_entry_t                  i_entry,
   input  logic                       i_pop,
   input  logic                       i_flush,
   output wb_entry_t                  o_head,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   wb_entry_t         mem_q [DEPTH];
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   // Flush wins over push/pop so a squash discards a same-cycle push as well.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (i_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (i_pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
         if (i_push)
            wr_ptr_d = wr_ptr_q + AW'(1);
         case ({i_push, i_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (i_push && !i_flush)
            mem_q[wr_ptr_q] <= i_entry;
      end
   end

   assign o_head  = mem_q[rd_ptr_q];
   assign o_count = count_q;

endmodule

// File: rtl/wb_retire_stage.sv
// rtl/wb_retire_stage.sv - writeback/retire stage: buffers ALU results, writes regfile, owns N/Z, resolves jumps
module wb_retire_stage
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_alu_out,
   input  logic              i_n,
   input  logic              i_z,
   input  logic [REG_AW-1:0] i_rd,
   input  logic              i_wr_en,
   input  logic              i_flag_en,
   input  logic [1:0]        i_br_cond,
   input  logic [DATA_W-1:0] i_br_target,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_rf_we,
   output logic [REG_AW-1:0] o_rf_waddr,
   output logic [DATA_W-1:0] o_rf_wdata,
   output logic              o_br_taken,
   output logic [DATA_W-1:0] o_br_target,
   output logic              o_flag_n,
   output logic              o_flag_z
);

   localparam int CW = $clog2(DEPTH+1);

   wb_entry_t     in_entry;
   wb_entry_t     head;
   logic [CW-1:0] count;
   logic          push, pop, taken, squash;
   logic          run_q, run_d;
   logic          flag_n_q, flag_n_d;
   logic          flag_z_q, flag_z_d;

   assign in_entry = '{
      data:      i_alu_out,
      n:         i_n,
      z:         i_z,
      rd:        i_rd,
      wr_en:     i_wr_en,
      flag_en:   i_flag_en,
      br_cond:   br_cond_e'(i_br_cond),
      br_target: i_br_target
   };

   // run_q keeps o_ready low through reset and for the first cycle after release.
   assign o_valid = i_reset_n & (count != '0);
   assign o_ready = i_reset_n & run_q & (count != CW'(DEPTH));

   assign push   = i_valid & o_ready;
   assign pop    = o_valid & i_ready;
   assign taken  = br_is_taken(head.br_cond, flag_n_q, flag_z_q);
   assign squash = pop & taken;

   assign o_rf_we     = o_valid & head.wr_en;
   assign o_rf_waddr  = head.rd;
   assign o_rf_wdata  = head.data;
   assign o_br_taken  = squash;
   assign o_br_target = head.br_target;
   assign o_flag_n    = flag_n_q;
   assign o_flag_z    = flag_z_q;

   wb_queue #(.DEPTH(DEPTH)) u_queue (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_push    (push),
      .i_entry   (in_entry),
      .i_pop     (pop),
      .i_flush   (squash),
      .o_head    (head),
      .o_count   (count)
   );

   always_comb begin
      run_d    = 1'b1;
      flag_n_d = flag_n_q;
      flag_z_d = flag_z_q;
      if (pop && head.flag_en) begin
         flag_n_d = head.n;
         flag_z_d = head.z;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         run_q    <= 1'b0;
         flag_n_q <= 1'b0;
         flag_z_q <= 1'b0;
      end else begin
         run_q    <= run_d;
         flag_n_q <= flag_n_d;
         flag_z_q <= flag_z_d;
      end
   end

endmodule

// File: tb/tb_wb_retire_stage.sv
// tb/tb_wb_retire_stage.sv - randomized and directed bench for wb_retire_stage against a queue-based model
module tb_wb_retire_stage;
   import cpu_pkg::*;

   localparam int DEPTH = 2;

   logic              clk = 1'b0;
   logic              i_reset_n = 1'b0;
   logic              i_valid = 1'b0;
   logic              o_ready;
   logic [DATA_W-1:0] i_alu_out = '0;
   logic              i_n = 1'b0;
   logic              i_z = 1'b0;
   logic [REG_AW-1:0] i_rd = '0;
   logic              i_wr_en = 1'b0;
   logic              i_flag_en = 1'b0;
   logic [1:0]        i_br_cond = '0;
   logic [DATA_W-1:0] i_br_target = '0;
   logic              o_valid;
   logic              i_ready = 1'b0;
   logic              o_rf_we;
   logic [REG_AW-1:0] o_rf_waddr;
   logic [DATA_W-1:0] o_rf_wdata;
   logic              o_br_taken;
   logic [DATA_W-1:0] o_br_target;
   logic              o_flag_n;
   logic              o_flag_z;

   always #5 clk = ~clk;

   wb_retire_stage #(.DEPTH(DEPTH)) dut (
      .i_clk       (clk),
      .i_reset_n   (i_reset_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_alu_out   (i_alu_out),
      .i_n         (i_n),
      .i_z         (i_z),
      .i_rd        (i_rd),
      .i_wr_en     (i_wr_en),
      .i_flag_en   (i_flag_en),
      .i_br_cond   (i_br_cond),
      .i_br_target (i_br_target),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_rf_we     (o_rf_we),
      .o_rf_waddr  (o_rf_waddr),
      .o_rf_wdata  (o_rf_wdata),
      .o_br_taken  (o_br_taken),
      .o_br_target (o_br_target),
      .o_flag_n    (o_flag_n),
      .o_flag_z    (o_flag_z)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain queue of pending entries plus architectural flags.
   wb_entry_t mq[$];
   logic      mfn = 1'b0, mfz = 1'b0, mrun = 1'b0;
   bit        model_on = 1'b0;

   always @(negedge clk) begin
      bit        ev, er, tk, mpop, mpush;
      wb_entry_t h, inc;
      if (model_on) begin
         ev = i_reset_n && (mq.size() != 0);
         er = i_reset_n && mrun && (mq.size() < DEPTH);
         h  = ev ? mq[0] : '0;
         tk = ev && ((h.br_cond == BR_ALWAYS) ||
                     (h.br_cond == BR_IF_N && mfn) ||
                     (h.br_cond == BR_IF_Z && mfz));
         chk("m_valid", {31'b0, o_valid}, {31'b0, ev});
         chk("m_ready", {31'b0, o_ready}, {31'b0, er});
         chk("m_rf_we", {31'b0, o_rf_we}, {31'b0, ev && h.wr_en});
         chk("m_br_taken", {31'b0, o_br_taken}, {31'b0, tk && i_ready});
         chk("m_flag_n", {31'b0, o_flag_n}, {31'b0, mfn});
         chk("m_flag_z", {31'b0, o_flag_z}, {31'b0, mfz});
         if (ev) begin
            chk("m_waddr", {29'b0, o_rf_waddr}, {29'b0, h.rd});
            chk("m_wdata", {16'b0, o_rf_wdata}, {16'b0, h.data});
            chk("m_target", {16'b0, o_br_target}, {16'b0, h.br_target});
         end
         if (!i_reset_n) begin
            mq.delete();
            mfn  = 1'b0;
            mfz  = 1'b0;
            mrun = 1'b0;
         end else begin
            mpop  = ev && i_ready;
            mpush = i_valid && er;
            inc = '{data: i_alu_out, n: i_n, z: i_z, rd: i_rd, wr_en: i_wr_en,
                    flag_en: i_flag_en, br_cond: br_cond_e'(i_br_cond), br_target: i_br_target};
            mrun = 1'b1;
            if (mpop && tk) begin
               mq.delete();
            end else begin
               if (mpop) begin
                  if (h.flag_en) begin
                     mfn = h.n;
                     mfz = h.z;
                  end
                  void'(mq.pop_front());
               end
               if (mpush)
                  mq.push_back(inc);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [15:0] d, input bit n, input bit z,
                        input logic [2:0] rd, input bit we, input bit fe,
                        input logic [1:0] c, input logic [15:0] t);
      i_valid     = v;
      i_alu_out   = d;
      i_n         = n;
      i_z         = z;
      i_rd        = rd;
      i_wr_en     = we;
      i_flag_en   = fe;
      i_br_cond   = c;
      i_br_target = t;
   endtask

   initial begin
      bit held;
      logic [1:0] c;

      // Reset hold with upstream asserting valid
      i_reset_n = 1'b0;
      i_ready   = 1'b1;
      drive(1, 16'h1234, 1, 1, 3'd7, 1, 1, 2'd0, 16'hffff);
      cyc();
      model_on = 1'b1;
      cyc();
      @(negedge clk);
      chk("rst_valid", {31'b0, o_valid}, 32'd0);
      chk("rst_ready", {31'b0, o_ready}, 32'd0);
      chk("rst_flags", {30'b0, o_flag_n, o_flag_z}, 32'd0);
      chk("rst_waddr", {29'b0, o_rf_waddr}, 32'd0);
      chk("rst_wdata", {16'b0, o_rf_wdata}, 32'd0);
      chk("rst_target", {16'b0, o_br_target}, 32'd0);
      chk("rst_rf_we", {31'b0, o_rf_we}, 32'd0);
      cyc();
      i_reset_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
      cyc();
      @(negedge clk);
      chk("release_ready", {31'b0, o_ready}, 32'd1);

      // Basic retire
      drive(1, 16'h0005, 0, 0, 3'd2, 1, 1, 2'd0, 0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
      @(negedge clk);
      chk("basic_valid", {31'b0, o_valid}, 32'd1);
      chk("basic_we", {31'b0, o_rf_we}, 32'd1);
      chk("basic_waddr", {29'b0, o_rf_waddr}, 32'd2);
      chk("basic_wdata", {16'b0, o_rf_wdata}, 32'h0005);
      cyc();
      @(negedge clk);
      chk("basic_empty", {31'b0, o_valid}, 32'd0);
      chk("basic_flags", {30'b0, o_flag_n, o_flag_z}, 32'd0);

      // Backpressure and ordering
      i_ready = 1'b0;
      drive(1, 16'd1, 0, 0, 3'd5, 1, 0, 2'd0, 0);
      cyc();
      drive(1, 16'd2, 0, 0, 3'd5, 1, 0, 2'd0, 0);
      cyc();
      drive(1, 16'd3, 0, 0, 3'd5, 1, 0, 2'd0, 0);
      @(negedge clk);
      chk("bp_full_ready", {31'b0, o_ready}, 32'd0);
      cyc();
      i_ready = 1'b1;
      @(negedge clk);
      chk("bp_order1", {16'b0, o_rf_wdata}, 32'd1);
      cyc();
      @(negedge clk);
      chk("bp_ready_back", {31'b0, o_ready}, 32'd1);
      chk("bp_order2", {16'b0, o_rf_wdata}, 32'd2);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
      @(negedge clk);
      chk("bp_order3", {16'b0, o_rf_wdata}, 32'd3);
      cyc();

      // Flag-dependent jump, taken then not taken
      drive(1, 16'h0000, 0, 1, 3'd1, 1, 1, 2'd0, 0);
      cyc();
      drive(1, 16'h0000, 0, 0, 3'd0, 0, 0, 2'd3, 16'h0040);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
      @(negedge clk);
      chk("brz_taken", {31'b0, o_br_taken}, 32'd1);
      chk("brz_target", {16'b0, o_br_target}, 32'h0040);
      chk("brz_flag_z", {31'b0, o_flag_z}, 32'd1);
      cyc();
      drive(1, 16'h0001, 0, 0, 3'd1, 1, 1, 2'd0, 0);
      cyc();
      drive(1, 16'h0000, 0, 0, 3'd0, 0, 0, 2'd3, 16'h0040);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
      @(negedge clk);
      chk("brz_not_valid", {31'b0, o_valid}, 32'd1);
      chk("brz_not_taken", {31'b0, o_br_taken}, 32'd0);
      cyc();

      // Squash from a full queue
      i_ready = 1'b0;
      drive(1, 16'h0000, 0, 0, 3'd0, 0, 0, 2'd1, 16'h0010);
      cyc();
      drive(1, 16'h0007, 1, 0, 3'd3, 1, 1, 2'd0, 0);
      cyc();
      drive(1, 16'h0009, 1, 1, 3'd3, 1, 1, 2'd0, 0);
      i_ready = 1'b1;
      @(negedge clk);
      chk("sq_taken", {31'b0, o_br_taken}, 32'd1);
      chk("sq_target", {16'b0, o_br_target}, 32'h0010);
      chk("sq_no_we", {31'b0, o_rf_we}, 32'd0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
      @(negedge clk);
      chk("sq_empty", {31'b0, o_valid}, 32'd0);
      chk("sq_flags", {30'b0, o_flag_n, o_flag_z}, 32'd0);
      cyc();

      // Squash that discards an accepted concurrent push
      drive(1, 16'h0000, 0, 0, 3'd0, 0, 0, 2'd1, 16'h0020);
      cyc();
      drive(1, 16'h0008, 1, 0, 3'd4, 1, 1, 2'd0, 0);
      @(negedge clk);
      chk("sq2_ready", {31'b0, o_ready}, 32'd1);
      chk("sq2_taken", {31'b0, o_br_taken}, 32'd1);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
      @(negedge clk);
      chk("sq2_empty", {31'b0, o_valid}, 32'd0);
      chk("sq2_flag_n", {31'b0, o_flag_n}, 32'd0);
      cyc();

      // Reset with a full queue
      drive(1, 16'h0011, 1, 0, 3'd6, 1, 1, 2'd0, 0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
      cyc();
      @(negedge clk);
      chk("mr_flag_n_set", {31'b0, o_flag_n}, 32'd1);
      i_ready = 1'b0;
      drive(1, 16'h0022, 0, 1, 3'd6, 1, 1, 2'd0, 0);
      cyc();
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
      i_reset_n = 1'b0;
      i_ready   = 1'b1;
      @(negedge clk);
      chk("mr_no_we", {31'b0, o_rf_we}, 32'd0);
      cyc();
      @(negedge clk);
      chk("mr_valid", {31'b0, o_valid}, 32'd0);
      chk("mr_flags", {30'b0, o_flag_n, o_flag_z}, 32'd0);
      i_reset_n = 1'b1;
      cyc();
      cyc();

      // Randomized traffic; upstream holds data while stalled
      held = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         if (!held) begin
            c = 2'($urandom_range(0, 3));
            drive($urandom_range(0, 99) < 60, 16'($urandom), 1'($urandom), 1'($urandom),
                  3'($urandom), 1'($urandom), (c == 2'd0) ? 1'($urandom) : 1'b0,
                  c, 16'($urandom));
         end
         i_ready   = $urandom_range(0, 99) < 65;
         i_reset_n = $urandom_range(0, 199) != 0;
         @(negedge clk);
         held = i_valid && !o_ready && i_reset_n;
         cyc();
      end

      drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
